// File: rtl/exu_shift_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : exu_shift_ctrl
//  Purpose  : EXU shift control. Decodes RV32I shift micro-ops, drives the
//             external barrel shifter and registers its result toward WBU.
//  Options  : define EXU_SHIFT_PERF_CNT_EN to add the shift_cnt counter port.
//  Revision : 1.0 - initial release
// ============================================================================
module exu_shift_ctrl #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_src1,
    input  logic [DATA_WIDTH-1:0] in_src2,
    input  logic [2:0]            in_funct3,
    input  logic                  in_funct7_5,
    input  logic [4:0]            in_rd,
    input  logic                  flush,
    output logic [DATA_WIDTH-1:0] sh_din,
    output logic [4:0]            sh_shamt,
    output logic                  sh_l_or_r,
    output logic                  sh_a_or_l,
    input  logic [DATA_WIDTH-1:0] sh_dout,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_result,
    output logic [4:0]            out_rd,
`ifdef EXU_SHIFT_PERF_CNT_EN
    output logic [31:0]           shift_cnt,
`endif
    output logic                  out_err
);

    localparam int       C_SHAMT_W   = 5;
    localparam bit [2:0] C_F3_SLL    = 3'b001;
    localparam bit [2:0] C_F3_SRL_RA = 3'b101;

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [DATA_WIDTH-1:0] r_result;
    logic [4:0]            r_rd;
    logic                  r_err;

    logic w_is_sll;
    logic w_is_srl;
    logic w_is_sra;
    logic w_illegal;
    logic w_accept;
    logic w_unused_src2_hi;

    // Only the low five bits of the shift source carry the amount.
    assign w_unused_src2_hi = ^in_src2[DATA_WIDTH-1:C_SHAMT_W];

    assign w_is_sll  = (in_funct3 == C_F3_SLL)    && !in_funct7_5;
    assign w_is_srl  = (in_funct3 == C_F3_SRL_RA) && !in_funct7_5;
    assign w_is_sra  = (in_funct3 == C_F3_SRL_RA) &&  in_funct7_5;
    assign w_illegal = !(w_is_sll || w_is_srl || w_is_sra);

    assign sh_din    = in_src1;
    assign sh_shamt  = in_src2[C_SHAMT_W-1:0];
    assign sh_l_or_r = w_is_sll;
    assign sh_a_or_l = w_is_sra;

    assign out_valid = (r_state == ST_FULL);
    assign in_ready  = !out_valid || out_ready;
    assign w_accept  = in_valid && in_ready && !flush;

    always_comb begin
        w_state_nxt = r_state;
        if (flush) begin
            w_state_nxt = ST_EMPTY;
        end else if (w_accept) begin
            w_state_nxt = ST_FULL;
        end else if (out_ready) begin
            w_state_nxt = ST_EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_EMPTY;
            r_result <= '0;
            r_rd     <= '0;
            r_err    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_result <= w_illegal ? '0 : sh_dout;
                r_rd     <= in_rd;
                r_err    <= w_illegal;
            end
        end
    end

    assign out_result = r_result;
    assign out_rd     = r_rd;
    assign out_err    = r_err;

`ifdef EXU_SHIFT_PERF_CNT_EN
    logic [31:0] r_shift_cnt;
    logic        w_cnt_inc;

    // Counts only legal results actually consumed by WBU; wraps naturally.
    assign w_cnt_inc = out_valid && out_ready && !flush && !r_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift_cnt <= '0;
        end else if (w_cnt_inc) begin
            r_shift_cnt <= r_shift_cnt + 32'd1;
        end
    end

    assign shift_cnt = r_shift_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_exu_shift_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_exu_shift_ctrl
//  Purpose  : Directed self-checking bench for exu_shift_ctrl with a
//             behavioural barrel shifter attached to the sh_* ports.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_exu_shift_ctrl;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_src1;
    logic [31:0] in_src2;
    logic [2:0]  in_funct3;
    logic        in_funct7_5;
    logic [4:0]  in_rd;
    logic        flush;
    logic [31:0] sh_din;
    logic [4:0]  sh_shamt;
    logic        sh_l_or_r;
    logic        sh_a_or_l;
    logic [31:0] sh_dout;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [4:0]  out_rd;
    logic        out_err;
`ifdef EXU_SHIFT_PERF_CNT_EN
    logic [31:0] shift_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    exu_shift_ctrl #(.DATA_WIDTH(32)) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_src1     (in_src1),
        .in_src2     (in_src2),
        .in_funct3   (in_funct3),
        .in_funct7_5 (in_funct7_5),
        .in_rd       (in_rd),
        .flush       (flush),
        .sh_din      (sh_din),
        .sh_shamt    (sh_shamt),
        .sh_l_or_r   (sh_l_or_r),
        .sh_a_or_l   (sh_a_or_l),
        .sh_dout     (sh_dout),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_rd      (out_rd),
`ifdef EXU_SHIFT_PERF_CNT_EN
        .shift_cnt   (shift_cnt),
`endif
        .out_err     (out_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in for the downstream combinational barrel shifter.
    always_comb begin
        if (sh_l_or_r)
            sh_dout = sh_din << sh_shamt;
        else if (sh_a_or_l)
            sh_dout = $unsigned($signed(sh_din) >>> sh_shamt);
        else
            sh_dout = sh_din >> sh_shamt;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic offer(input logic [2:0] f3, input logic f75,
                         input logic [31:0] s1, input logic [31:0] s2,
                         input logic [4:0] rd);
        in_funct3   = f3;
        in_funct7_5 = f75;
        in_src1     = s1;
        in_src2     = s2;
        in_rd       = rd;
        in_valid    = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        in_src1     = '0;
        in_src2     = '0;
        in_funct3   = '0;
        in_funct7_5 = 1'b0;
        in_rd       = '0;
        flush       = 1'b0;
        out_ready   = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_result", out_result, 0);
        check("rst_out_rd", out_rd, 0);
        check("rst_out_err", out_err, 0);
        check("rst_in_ready", in_ready, 1);
        rst_n = 1'b1;
        cyc();

        // SLL 1 << 31
        offer(3'b001, 1'b0, 32'h0000_0001, 32'h0000_001F, 5'd3);
        #1;
        check("sll_sh_din", sh_din, 32'h0000_0001);
        check("sll_sh_shamt", sh_shamt, 31);
        check("sll_l_or_r", sh_l_or_r, 1);
        check("sll_a_or_l", sh_a_or_l, 0);
        cyc();
        check("sll_valid", out_valid, 1);
        check("sll_result", out_result, 32'h8000_0000);
        check("sll_err", out_err, 0);
        check("sll_rd", out_rd, 3);

        // SRA then SRL back-to-back
        offer(3'b101, 1'b1, 32'h8000_0000, 32'h0000_0004, 5'd5);
        #1;
        check("sra_a_or_l", sh_a_or_l, 1);
        check("b2b_ready0", in_ready, 1);
        cyc();
        check("sra_result", out_result, 32'hF800_0000);
        check("sra_rd", out_rd, 5);
        offer(3'b101, 1'b0, 32'h8000_0000, 32'h0000_0004, 5'd6);
        #1;
        check("b2b_ready1", in_ready, 1);
        cyc();
        check("srl_valid", out_valid, 1);
        check("srl_result", out_result, 32'h0800_0000);
        check("srl_rd", out_rd, 6);

        // Shamt 0 pass-through, then back-pressure for three cycles
        offer(3'b001, 1'b0, 32'h1234_5678, 32'h0000_0000, 5'd7);
        cyc();
        check("shamt0_result", out_result, 32'h1234_5678);
        out_ready = 1'b0;
        offer(3'b101, 1'b0, 32'hF000_0000, 32'h0000_0008, 5'd8);
        for (int i = 0; i < 3; i++) begin
            #1;
            check("stall_in_ready", in_ready, 0);
            check("stall_valid", out_valid, 1);
            check("stall_result", out_result, 32'h1234_5678);
            check("stall_rd", out_rd, 7);
            cyc();
        end
        out_ready = 1'b1;
        #1;
        check("release_in_ready", in_ready, 1);
        cyc();
        check("queued_result", out_result, 32'h00F0_0000);
        check("queued_rd", out_rd, 8);

        // Illegal encodings and SRA by 31 of a negative value
        offer(3'b000, 1'b0, 32'hFFFF_FFFF, 32'h0000_0003, 5'd9);
        #1;
        check("ill_l_or_r", sh_l_or_r, 0);
        check("ill_a_or_l", sh_a_or_l, 0);
        cyc();
        check("ill_valid", out_valid, 1);
        check("ill_result", out_result, 0);
        check("ill_err", out_err, 1);
        check("ill_rd", out_rd, 9);
        offer(3'b001, 1'b1, 32'h0000_00FF, 32'h0000_0001, 5'd10);
        cyc();
        check("ill_sll_f7_result", out_result, 0);
        check("ill_sll_f7_err", out_err, 1);
        offer(3'b101, 1'b1, 32'h8000_0001, 32'hFFFF_FFFF, 5'd11);
        cyc();
        check("sra31_result", out_result, 32'hFFFF_FFFF);
        check("sra31_err", out_err, 0);

        // Flush while FULL drops the offered op
        offer(3'b001, 1'b0, 32'h0000_0001, 32'h0000_0001, 5'd12);
        flush = 1'b1;
        #1;
        check("flush_in_ready", in_ready, 1);
        cyc();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush_valid", out_valid, 0);
        cyc();
        check("flush_no_capture", out_valid, 0);

        // Flush dominates a stalled consumer
        offer(3'b001, 1'b0, 32'h0000_0003, 32'h0000_0002, 5'd13);
        cyc();
        check("pre_flush_result", out_result, 32'h0000_000C);
        out_ready = 1'b0;
        flush     = 1'b1;
        cyc();
        check("flush_stall_valid", out_valid, 0);
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;

        // Async reset mid-transfer discards the held payload
        offer(3'b101, 1'b0, 32'h0000_0100, 32'h0000_0004, 5'd14);
        cyc();
        check("pre_rst_result", out_result, 32'h0000_0010);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid", out_valid, 0);
        check("arst_result", out_result, 0);
        check("arst_rd", out_rd, 0);
`ifdef EXU_SHIFT_PERF_CNT_EN
        check("arst_cnt", shift_cnt, 0);
`endif
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        cyc();
        check("post_rst_idle", out_valid, 0);

        // Five legal handshakes, then an illegal one
        for (int i = 0; i < 5; i++) begin
            offer(3'b001, 1'b0, 32'(i + 1), 32'h0000_0001, 5'(i));
            cyc();
        end
        in_valid = 1'b0;
        check("last_of_five", out_result, 32'h0000_000A);
        cyc();
        check("drain_valid", out_valid, 0);
`ifdef EXU_SHIFT_PERF_CNT_EN
        check("cnt_five", shift_cnt, 5);
`endif
        offer(3'b010, 1'b0, 32'h0000_0001, 32'h0000_0001, 5'd1);
        cyc();
        in_valid = 1'b0;
        check("ill2_err", out_err, 1);
        cyc();
`ifdef EXU_SHIFT_PERF_CNT_EN
        check("cnt_ill_skip", shift_cnt, 5);
`endif
        offer(3'b001, 1'b0, 32'h0000_0001, 32'h0000_0002, 5'd2);
        cyc();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("pre_rst2_valid", out_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst2_valid", out_valid, 0);
`ifdef EXU_SHIFT_PERF_CNT_EN
        check("arst2_cnt", shift_cnt, 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        cyc();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/exu_shift_ctrl.md
# exu_shift_ctrl

Execute-stage control and pipeline register that sits directly upstream of the combinational 32-bit barrel shifter in the NPC EXU. Accepts decoded shift micro-ops from IDU over a valid/ready handshake and drives the shifter's data and control inputs. Captures the shifter result into a one-entry output register and hands it to WBU over a second valid/ready handshake. Covers RV32I SLL/SRL/SRA and SLLI/SRLI/SRAI.

## Interface
- DATA_WIDTH, 32, operand/result width; only 32 supported (shamt is 5 bits).
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  IDU offers a shift micro-op.
- in_ready  out  1  block accepts this cycle.
- in_src1  in  32  value to shift.
- in_src2  in  32  shift amount source (rs2 or imm); only [4:0] used.
- in_funct3  in  3  instruction funct3.
- in_funct7_5  in  1  instruction bit 30 (arith/logical select).
- in_rd  in  5  destination register index, passed through.
- flush  in  1  synchronous pipeline flush.
- sh_din  out  32  to shifter Din.
- sh_shamt  out  5  to shifter Shamt.
- sh_l_or_r  out  1  to shifter L_or_R; 1 = left.
- sh_a_or_l  out  1  to shifter A_or_L; 1 = arithmetic.
- sh_dout  in  32  from shifter Dout.
- out_valid  out  1  result held for WBU.
- out_ready  in  1  WBU consumes.
- out_result  out  32  shift result.
- out_rd  out  5  registered in_rd.
- out_err  out  1  accepted op had illegal funct encoding.

## Operation
- Shifter path combinational from in_*: sh_din = in_src1, sh_shamt = in_src2[4:0].
- Decode: funct3=001, f7_5=0 → SLL (l_or_r=1, a_or_l=0); funct3=101, f7_5=0 → SRL (0,0); funct3=101, f7_5=1 → SRA (0,1).
- Any other combination (incl. 001 with f7_5=1) is illegal: drive (0,0), captured result forced to 0, out_err=1.
- Two states on out_valid: EMPTY (out_valid=0), FULL (out_valid=1).
- in_ready = !out_valid || out_ready (full-throughput register; back-to-back accepts with no bubble).
- Accept (in_valid && in_ready && !flush): out_result ← sh_dout (or 0 if illegal), out_rd ← in_rd, out_err ← illegal, out_valid ← 1.
- FULL && out_ready && no accept → EMPTY.
- FULL && out_ready && accept → stays FULL with new payload.
- FULL && !out_ready → payload and out_valid held stable; in_ready=0.
- flush: out_valid ← 0 next edge; same-cycle in_valid is dropped (in_ready is still computed normally but no capture); flush dominates out_ready.
- Shamt 0 passes in_src1 unchanged; shamt 31 SRA of negative yields 0xFFFFFFFF.

## Timing
- Reset (rst_n low, async): out_valid=0, out_result=0, out_rd=0, out_err=0; shift counter (if built) = 0. in_ready=1 immediately after reset.
- Latency: 1 cycle from accepting edge to out_valid.
- Throughput: 1 op/cycle while out_ready=1.
- Reset asserted mid-transfer discards held payload; no output until a new accept after release.
- out_* are registered; sh_* and in_ready are combinational.

## Configuration
- EXU_SHIFT_PERF_CNT_EN defined: adds output port shift_cnt (out, 32) counting out handshakes (out_valid && out_ready && !flush) with out_err=0; wraps 0xFFFFFFFF → 0; illegal ops not counted.
- Not defined: port and counter absent; all other behaviour identical.

## Test plan
- Reset, then SLL src1=0x0000_0001, src2=0x1F, out_ready=1 → next cycle out_valid=1, out_result=0x8000_0000, out_err=0.
- SRA src1=0x8000_0000 shamt=4 then SRL same operands back-to-back → 0xF800_0000 then 0x0800_0000 on consecutive cycles, in_ready held 1.
- out_ready=0 with FULL for 3 cycles → in_ready=0, out_result stable; raise out_ready → next queued op delivered the following cycle.
- funct3=000 → out_valid=1, out_result=0, out_err=1; counter unchanged with EXU_SHIFT_PERF_CNT_EN.
- flush with in_valid=1 while FULL → next cycle out_valid=0, offered op not captured.
- With EXU_SHIFT_PERF_CNT_EN, preload-by-stimulus 5 legal handshakes → shift_cnt=5; async rst_n pulse mid-stream → shift_cnt=0, out_valid=0 immediately.
